// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates the single-ported data memory between the MEM-stage cpu port and the debug/loader port.
// Latency : write ack 1 cycle after the request is sampled in IDLE; read ack 1+RD_LAT cycles after.
// Backpr. : requesters hold req until their ack; cpu_stall = cpu_req & ~cpu_ack; dbg is forced a grant after STARVE_MAX contested cpu wins.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack/cpu_stall : pipeline MEM-stage port
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_rdata/dbg_ack           : debug/loader port
//   mem_addr/mem_wdata/mem_write/mem_read <- mem_rdata                : data memory side
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD} state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;          // 0 = cpu, 1 = dbg
    logic              we_q, we_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [ST_W-1:0]   starve_cnt, starve_nx;
    logic [LAT_W-1:0]  lat_cnt, lat_nx;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nx;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_nx;
    logic              ack;
    logic              pick_dbg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_cnt  <= '0;
            lat_cnt     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            we_q        <= we_nx;
            addr_q      <= addr_nx;
            wdata_q     <= wdata_nx;
            starve_cnt  <= starve_nx;
            lat_cnt     <= lat_nx;
            cpu_rdata_q <= cpu_rdata_nx;
            dbg_rdata_q <= dbg_rdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        we_nx        = we_q;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        starve_nx    = starve_cnt;
        lat_nx       = lat_cnt;
        cpu_rdata_nx = cpu_rdata_q;
        dbg_rdata_nx = dbg_rdata_q;
        ack          = 1'b0;
        pick_dbg     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // dbg wins when alone, or when contested and the cpu has used up its streak.
                    pick_dbg = dbg_req && (!cpu_req || (starve_cnt == ST_W'(STARVE_MAX)));
                    if (pick_dbg) begin
                        starve_nx = '0;
                    end else if (dbg_req) begin
                        // contested cpu win; cannot be at the limit here, so no overflow
                        starve_nx = starve_cnt + 1'b1;
                    end
                    owner_nx = pick_dbg;
                    we_nx    = pick_dbg ? dbg_we    : cpu_we;
                    addr_nx  = pick_dbg ? dbg_addr  : cpu_addr;
                    wdata_nx = pick_dbg ? dbg_wdata : cpu_wdata;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_write = we_q;
                mem_read  = ~we_q;
                if (we_q) begin
                    ack      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    lat_nx   = LAT_W'(RD_LAT - 1);
                    state_nx = WAIT_RD;
                end
            end
            WAIT_RD: begin
                mem_addr = addr_q;
                if (lat_cnt == '0) begin
                    ack = 1'b1;
                    if (owner) dbg_rdata_nx = mem_rdata;
                    else       cpu_rdata_nx = mem_rdata;
                    state_nx = IDLE;
                end else begin
                    lat_nx = lat_cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_ack   = ack & ~owner;
    assign dbg_ack   = ack &  owner;
    // the captured word is presented in the ack cycle itself, ahead of the register update
    assign cpu_rdata = cpu_rdata_nx;
    assign dbg_rdata = dbg_rdata_nx;
    // forced low during reset so every output reads 0 while reset is asserted
    assign cpu_stall = reset & cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter (RD_LAT=3, STARVE_MAX=4) with a behavioural memory.
// Latency : expects write ack 1 cycle and read ack 4 cycles after the request is sampled.
// Backpr. : requests are held until ack and dropped in the following IDLE cycle.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RD_LAT = 3;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // behavioural memory: unwritten words read as A5A5_0000_0000_<addr>; the read pipe
    // carries junk except RD_LAT cycles after a read strobe
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] pipe [RD_LAT];
    bit            init_done;
    int unsigned   cyc;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
            init_done = 1'b1;
        end
        pipe[0] <= mem_read ? mem[mem_addr] : {32'hBAD0_BAD0, cyc};
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_write) mem[mem_addr] = mem_wdata;
        cyc <= cyc + 1;
    end
    assign mem_rdata = pipe[RD_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // scoreboard of completions in expected order
    typedef struct {
        bit            port;   // 0 cpu, 1 dbg
        bit            rd;
        logic [DW-1:0] data;
    } sb_t;
    sb_t           sb[$];
    sb_t           mon_e;
    logic [DW-1:0] last_cpu = '0;
    logic [DW-1:0] last_dbg = '0;

    always @(negedge clk) begin
        if (!reset) begin
            last_cpu = '0;
            last_dbg = '0;
        end else if (cpu_ack || dbg_ack) begin
            chk("ack_exclusive", 64'(cpu_ack & dbg_ack), 64'd0);
            if (sb.size() == 0) begin
                fail_now("sb_unexpected_ack");
            end else begin
                mon_e = sb.pop_front();
                chk("sb_port", 64'(dbg_ack), 64'(mon_e.port));
                if (mon_e.port) begin
                    chk("sb_dbg_rdata", dbg_rdata, mon_e.rd ? mon_e.data : last_dbg);
                    if (mon_e.rd) last_dbg = mon_e.data;
                    chk("sb_cpu_rdata_hold", cpu_rdata, last_cpu);
                end else begin
                    chk("sb_cpu_rdata", cpu_rdata, mon_e.rd ? mon_e.data : last_cpu);
                    if (mon_e.rd) last_cpu = mon_e.data;
                    chk("sb_dbg_rdata_hold", dbg_rdata, last_dbg);
                end
            end
        end
    end

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    // called just after a rising edge; leaves just after the edge following the ack
    task automatic issue(input vec_t v);
        int  k;
        bit  done;
        bit  ack;
        sb_t e;
        e.port = v.port;
        e.rd   = !v.we;
        e.data = v.exp_rdata;
        sb.push_back(e);
        if (v.port) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            ack = v.port ? dbg_ack : cpu_ack;
            if (k == 0) chk("idle_mem_addr", 64'(mem_addr), 64'd0);
            if (k == 1) begin
                chk("access_write", 64'(mem_write), 64'(v.we));
                chk("access_read", 64'(mem_read), 64'(!v.we));
                chk("access_addr", 64'(mem_addr), 64'(v.addr));
                if (v.we) chk("access_wdata", mem_wdata, v.wdata);
            end
            if (k > 1) chk("strobes_quiet", 64'({mem_write, mem_read}), 64'd0);
            if (!v.port) chk("cpu_stall", 64'(cpu_stall), 64'(!ack));
            if (ack) begin
                chk("ack_latency", 64'(k), 64'(v.exp_lat));
                done = 1'b1;
            end else begin
                k++;
            end
        end
        if (!done) fail_now("ack_timeout");
        @(posedge clk);
        #1;
        if (v.port) begin
            dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        end else begin
            cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cpu_ack"}, 64'(cpu_ack), 64'd0);
        chk({tag, "_dbg_ack"}, 64'(dbg_ack), 64'd0);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 64'd0);
        chk({tag, "_dbg_rdata"}, dbg_rdata, 64'd0);
    endtask

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  da;
        int  ca;
        int  spurious;
        sb_t e;

        tbl[0] = '{0, 1, 10'h010, 64'h0000_0000_0000_DEAD, 64'h0, 1};
        tbl[1] = '{0, 0, 10'h010, 64'h0, 64'h0000_0000_0000_DEAD, 4};
        tbl[2] = '{1, 1, 10'h3F8, 64'h0123_4567_89AB_CDEF, 64'h0, 1};
        tbl[3] = '{1, 0, 10'h3F8, 64'h0, 64'h0123_4567_89AB_CDEF, 4};
        tbl[4] = '{0, 0, 10'h000, 64'h0, 64'hA5A5_0000_0000_0000, 4};
        tbl[5] = '{1, 0, 10'h010, 64'h0, 64'h0000_0000_0000_DEAD, 4};
        tbl[6] = '{0, 1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
        tbl[7] = '{0, 0, 10'h3FF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4};
        tbl[8] = '{1, 0, 10'h200, 64'h0, 64'hA5A5_0000_0000_0200, 4};
        tbl[9] = '{0, 0, 10'h3F8, 64'h0, 64'h0123_4567_89AB_CDEF, 4};

        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_cpu_stall", 64'(cpu_stall), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // single-port accesses, each presented in the IDLE cycle after the previous ack
        for (int i = 0; i < 10; i++) issue(tbl[i]);

        // both ports requesting continuously: four cpu grants, then a forced dbg grant
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            e.port = (i % 5 == 4);
            e.rd   = 1'b0;
            e.data = '0;
            sb.push_back(e);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 64'h1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h030; dbg_wdata = 64'h2222;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 10; k++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) cnt++;
        end
        chk("starve_grant_count", 64'(cnt), 64'd10);
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        // dbg read in flight when cpu_req rises: dbg acks at 4, cpu granted after, acks at 9
        e.port = 1'b1; e.rd = 1'b1; e.data = 64'h0000_0000_0000_DEAD;
        sb.push_back(e);
        e.port = 1'b0; e.rd = 1'b1; e.data = 64'h0123_4567_89AB_CDEF;
        sb.push_back(e);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h010;
        da = -1;
        ca = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (dbg_ack && da < 0) da = k;
            if (cpu_ack && ca < 0) ca = k;
            if (k == 3) begin
                chk("wait_addr_held", 64'(mem_addr), 64'h010);
                chk("wait_no_strobe", 64'({mem_write, mem_read}), 64'd0);
                chk("wait_cpu_stall", 64'(cpu_stall), 64'd1);
            end
            @(posedge clk);
            #1;
            if (k == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3F8; end
            if (k == da) begin dbg_req = 1'b0; dbg_addr = '0; end
            if (k == ca) begin cpu_req = 1'b0; cpu_addr = '0; end
        end
        chk("contend_dbg_ack_cycle", 64'(da), 64'd4);
        chk("contend_cpu_ack_cycle", 64'(ca), 64'd9);

        // reset asserted while a cpu read waits on memory
        e.port = 1'b0; e.rd = 1'b1; e.data = 64'h0123_4567_89AB_CDEF;
        sb.push_back(e);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3F8;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk_outputs_zero("abort");
        sb.delete();
        cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) spurious++;
        end
        chk("abort_no_spurious_ack", 64'(spurious), 64'd0);
        @(posedge clk);
        #1;
        issue(tbl[9]);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
